// File: rtl/noc_rr_arbiter_n.sv
// N-to-1 valid/ready packet arbiter with one registered output stage.
// Round-robin or fixed-priority grant; each output packet carries its source index.
module noc_rr_arbiter_n #(
    parameter int N     = 4,
    parameter int WIDTH = 57,
    parameter int MODE  = 0,
    localparam int SRC_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]   out_src,
    input  logic               out_ready
);

    localparam int unsigned NU = N;

    logic [WIDTH-1:0] chan_data [N];
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SRC_W-1:0] out_src_q;
    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_d;
    logic [SRC_W-1:0] search_base;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_found;
    logic             load;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // (base + off) mod N for base < N and off <= N.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NU) begin
            s = s - NU;
        end
        return s[SRC_W-1:0];
    endfunction

    // Fixed priority is round-robin search anchored permanently at index 0.
    assign search_base = (MODE == 1) ? '0 : rr_ptr_q;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && in_valid[wrap_add(search_base, k)]) begin
                grant_idx   = wrap_add(search_base, k);
                grant_found = 1'b1;
            end
        end
    end

    // rst_n gates load so in_ready stays low for the whole reset window.
    assign load     = rst_n && (!out_valid_q || out_ready) && (|in_valid);
    assign in_ready = load ? (N'(1) << grant_idx) : '0;
    assign rr_ptr_d = (MODE == 0) ? wrap_add(grant_idx, 1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= chan_data[grant_idx];
            out_src_q   <= grant_idx;
            rr_ptr_q    <= rr_ptr_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/noc_rr_arbiter_n.md
Name: noc_rr_arbiter_n

Overview:
- Clocked, parametrised N-to-1 packet arbiter for the NoC router output stage; successor to the two-input alternating arbiter.
- Merges N valid/ready input channels onto one registered output channel, one packet per cycle.
- Selectable round-robin or fixed-priority mode.
- Tags each output packet with the winning input index so downstream routing and debug logic can identify its source.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- WIDTH, 57, packet width in bits.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_W, $clog2(N), width of the source-index tag; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N  per-channel request; bit i belongs to channel i.
- in_data  in  N*WIDTH  flattened packets; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept, one-hot or zero.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH  registered packet.
- out_src  out  SRC_W  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready=0 for the whole time rst_n is low.
  - Any held packet is discarded.
  - Normal operation resumes on the first rising clk edge after deassertion.
- Transfers:
  - An input transfer occurs on an edge where in_valid[i] && in_ready[i].
  - An output transfer occurs on an edge where out_valid && out_ready.
- Load enable: load = (!out_valid || out_ready) && |in_valid. This is combinational and includes the out_ready path, so a full register can drain and reload on the same edge.
- Grant, computed combinationally each cycle:
  - Round-robin (MODE=0): search indices rr_ptr, rr_ptr+1, ... modulo N; the first asserted in_valid wins.
  - Fixed (MODE=1): the lowest asserted index wins.
  - in_ready = load ? onehot(winner) : 0.
  - At most one in_ready bit is ever high.
- Register update on a load edge: out_data <= winner packet, out_src <= winner index, out_valid <= 1.
- Drain-only edge (output transfer, no load): out_valid <= 0. out_data and out_src hold their last value.
- Stall (out_valid && !out_ready):
  - in_ready=0.
  - out_valid, out_data and out_src are held stable until accepted.
  - A source must hold in_valid and in_data stable until its own transfer.
- Pointer (MODE=0 only):
  - On a load edge, rr_ptr <= (winner+1) mod N. It wraps from N-1 to 0.
  - rr_ptr is unchanged when there is no load, including during a stall or when all in_valid are low.
  - MODE=1 ignores rr_ptr; it stays 0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 packet per cycle while out_ready=1.
- Fairness (MODE=0): with all N requesting continuously, each channel is granted exactly once in every N consecutive grants. No channel waits more than N-1 grants.
- Packet integrity: no packet is dropped, duplicated or reordered within a channel, except when reset is applied.
- Simultaneous drain and load in one edge: the new packet replaces the old one and out_valid stays 1.
- in_valid deasserted before grant (protocol violation): no state corruption; the channel is simply not granted.
- Assertions in the bench:
  - $onehot0(in_ready).
  - out_data stable while out_valid && !out_ready.

Test Plan:
- Reset: drive rst_n low mid-stall with out_valid=1 -> out_valid, out_data, out_src and in_ready are 0 immediately, without waiting for a clock edge; after release, the next request is granted on the first edge.
- Single requester: N=4, only ch2 valid with data 57'h1A5, out_ready=1 -> in_ready=4'b0100 and, one edge later, out_valid=1, out_data=57'h1A5, out_src=2; rr_ptr=3.
- Round-robin full contention: MODE=0, all 4 valid continuously, out_ready=1, starting from reset -> out_src sequence 0,1,2,3,0,1,2,3 on consecutive cycles with out_valid held at 1.
- Fixed priority: MODE=1, ch1 and ch3 valid continuously -> out_src stays 1 every cycle and ch3 in_ready stays 0; drop ch1 -> ch3 is granted the next cycle.
- Backpressure: out_ready=0 for 5 cycles with ch0 and ch1 valid -> in_ready=0 throughout, out_data frozen, rr_ptr unchanged; raise out_ready -> the held packet is accepted and the next grant loads on the same edge.
- Wrap and idle gaps: rr_ptr=3, only ch0 and ch3 valid -> ch3 is granted first and then ch0 (rr_ptr 3->0->1); insert 3 all-idle cycles -> rr_ptr stays 1 and out_valid drops after the drain.
